// File: rtl/cpu_writeback.sv
// Stage-5 writeback sequencer: turns one retire bundle into a run of stack
// commands (pop first, then up to two pushes) on the stack-update interface.
module cpu_writeback #(
  parameter int WIDTH = 35,
  parameter int POPW  = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_4a,
  input  logic             kill_4a,
  input  logic [POPW-1:0]  st__to_pop_4a,
  input  logic [1:0]       c__to_push_4a,
  input  logic [WIDTH-1:0] res_4a,
  input  logic [WIDTH-1:0] aux_4a,
  output logic             busy_5a,
  output logic             st__pop_5a,
  output logic [POPW-1:0]  st__to_pop_5a,
  output logic             st__push_5a,
  output logic [WIDTH-1:0] st__to_push_5a,
  output logic [31:0]      retired_5a
);

  typedef enum logic [1:0] {IDLE, POP, PUSH_A, PUSH_B} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       code_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] aux_q;

  logic             accept;
  logic [1:0]       src_code;
  logic [WIDTH-1:0] src_res;
  logic [WIDTH-1:0] src_aux;
  logic             pop_nxt;
  logic [POPW-1:0]  pop_cnt_nxt;
  logic             push_nxt;
  logic [WIDTH-1:0] push_val_nxt;

  // Busy only when another command of the same bundle still follows this one.
  assign busy_5a = ((state == POP) && (code_q != 2'd0)) ||
                   ((state == PUSH_A) && code_q[1]);

  assign accept = valid_4a && !kill_4a && !busy_5a;

  always_comb begin
    src_code     = accept ? c__to_push_4a : code_q;
    src_res      = accept ? res_4a : res_q;
    src_aux      = accept ? aux_4a : aux_q;
    state_nxt    = IDLE;
    if (busy_5a) begin
      state_nxt = (state == POP) ? PUSH_A : PUSH_B;
    end else if (accept) begin
      if (st__to_pop_4a != '0) begin
        state_nxt = POP;
      end else if (c__to_push_4a != 2'd0) begin
        state_nxt = PUSH_A;
      end
    end

    // POP is only ever entered straight from an accept, so the count comes from the inputs.
    pop_nxt      = (state_nxt == POP);
    pop_cnt_nxt  = pop_nxt ? st__to_pop_4a : '0;
    push_nxt     = (state_nxt == PUSH_A) || (state_nxt == PUSH_B);
    push_val_nxt = '0;
    if (state_nxt == PUSH_A) begin
      push_val_nxt = (src_code == 2'd3) ? src_aux : src_res;
    end else if (state_nxt == PUSH_B) begin
      push_val_nxt = (src_code == 2'd3) ? src_res : src_aux;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      code_q         <= 2'd0;
      res_q          <= '0;
      aux_q          <= '0;
      st__pop_5a     <= 1'b0;
      st__to_pop_5a  <= '0;
      st__push_5a    <= 1'b0;
      st__to_push_5a <= '0;
      retired_5a     <= 32'd0;
    end else begin
      state          <= state_nxt;
      st__pop_5a     <= pop_nxt;
      st__to_pop_5a  <= pop_cnt_nxt;
      st__push_5a    <= push_nxt;
      st__to_push_5a <= push_val_nxt;
      if (accept) begin
        code_q     <= c__to_push_4a;
        res_q      <= res_4a;
        aux_q      <= aux_4a;
        retired_5a <= retired_5a + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_writeback.sv
// Bench for cpu_writeback: directed vector table, randomized run against a
// command-queue reference model, and a retired-counter wrap sequence.
module tb_cpu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_4a;
  logic        kill_4a;
  logic [10:0] st__to_pop_4a;
  logic [1:0]  c__to_push_4a;
  logic [34:0] res_4a;
  logic [34:0] aux_4a;
  logic        busy_5a;
  logic        st__pop_5a;
  logic [10:0] st__to_pop_5a;
  logic        st__push_5a;
  logic [34:0] st__to_push_5a;
  logic [31:0] retired_5a;

  int checks = 0;
  int errors = 0;

  cpu_writeback dut (
    .clk            (clk),
    .rst            (rst),
    .valid_4a       (valid_4a),
    .kill_4a        (kill_4a),
    .st__to_pop_4a  (st__to_pop_4a),
    .c__to_push_4a  (c__to_push_4a),
    .res_4a         (res_4a),
    .aux_4a         (aux_4a),
    .busy_5a        (busy_5a),
    .st__pop_5a     (st__pop_5a),
    .st__to_pop_5a  (st__to_pop_5a),
    .st__push_5a    (st__push_5a),
    .st__to_push_5a (st__to_push_5a),
    .retired_5a     (retired_5a)
  );

  always #5 clk = ~clk;

  // Reference model: the command being shown this cycle plus the commands still queued behind it.
  typedef struct {
    bit          is_pop;
    logic [34:0] val;
  } cmd_t;

  cmd_t        m_rest[$];
  cmd_t        m_cur;
  bit          m_cur_valid = 1'b0;
  logic [31:0] m_cnt = 32'd0;

  typedef struct {
    logic        rst, valid, kill;
    logic [10:0] pop;
    logic [1:0]  code;
    logic [34:0] r, a;
    logic        busy, spop;
    logic [10:0] pcnt;
    logic        spush;
    logic [34:0] pval;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic r_rst, input logic r_valid, input logic r_kill,
                                 input logic [10:0] r_pop, input logic [1:0] r_code,
                                 input logic [34:0] r_r, input logic [34:0] r_a,
                                 input logic e_busy, input logic e_spop, input logic [10:0] e_pcnt,
                                 input logic e_spush, input logic [34:0] e_pval,
                                 input logic [31:0] e_ret);
    vec_t v;
    v.rst = r_rst; v.valid = r_valid; v.kill = r_kill; v.pop = r_pop; v.code = r_code;
    v.r = r_r; v.a = r_a; v.busy = e_busy; v.spop = e_spop; v.pcnt = e_pcnt;
    v.spush = e_spush; v.pval = e_pval; v.ret = e_ret;
    vecs.push_back(v);
  endfunction

  task automatic checkField(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic modelStep();
    cmd_t lst[$];
    cmd_t c;
    if (rst) begin
      m_rest.delete();
      m_cur_valid = 1'b0;
      m_cnt = 32'd0;
    end else if (m_rest.size() > 0) begin
      m_cur = m_rest.pop_front();
      m_cur_valid = 1'b1;
    end else if (valid_4a && !kill_4a) begin
      m_cnt = m_cnt + 32'd1;
      if (st__to_pop_4a != 11'd0) begin
        c.is_pop = 1'b1; c.val = {24'd0, st__to_pop_4a}; lst.push_back(c);
      end
      c.is_pop = 1'b0;
      case (c__to_push_4a)
        2'd1: begin c.val = res_4a; lst.push_back(c); end
        2'd2: begin c.val = res_4a; lst.push_back(c); c.val = aux_4a; lst.push_back(c); end
        2'd3: begin c.val = aux_4a; lst.push_back(c); c.val = res_4a; lst.push_back(c); end
        default: ;
      endcase
      m_cur_valid = (lst.size() > 0);
      if (m_cur_valid) m_cur = lst.pop_front();
      m_rest = lst;
    end else begin
      m_cur_valid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic s_rst, input logic s_valid, input logic s_kill,
                               input logic [10:0] s_pop, input logic [1:0] s_code,
                               input logic [34:0] s_r, input logic [34:0] s_a);
    rst = s_rst; valid_4a = s_valid; kill_4a = s_kill;
    st__to_pop_4a = s_pop; c__to_push_4a = s_code; res_4a = s_r; aux_4a = s_a;
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput();
    bit          e_pop, e_push;
    logic [10:0] e_pcnt;
    logic [34:0] e_pval;
    e_pop  = m_cur_valid && m_cur.is_pop;
    e_push = m_cur_valid && !m_cur.is_pop;
    e_pcnt = e_pop ? m_cur.val[10:0] : 11'd0;
    e_pval = e_push ? m_cur.val : 35'd0;
    checkField("model busy", {34'd0, busy_5a}, {34'd0, m_rest.size() > 0});
    checkField("model pop strobe", {34'd0, st__pop_5a}, {34'd0, e_pop});
    checkField("model pop count", {24'd0, st__to_pop_5a}, {24'd0, e_pcnt});
    checkField("model push strobe", {34'd0, st__push_5a}, {34'd0, e_push});
    checkField("model push value", st__to_push_5a, e_pval);
    checkField("model retired", {3'd0, retired_5a}, {3'd0, m_cnt});
  endtask

  initial begin
    logic [63:0] t;
    logic [10:0] rp;
    rst = 1'b1; valid_4a = 1'b0; kill_4a = 1'b0;
    st__to_pop_4a = 11'd0; c__to_push_4a = 2'd0; res_4a = 35'd0; aux_4a = 35'd0;

    // reset, then reset landing in the POP cycle of a pop-2/code-2 bundle
    addVec(1'b1, 1'b0, 1'b0, 11'd0, 2'd0, 35'd0, 35'd0,   1'b0, 1'b0, 11'd0, 1'b0, 35'd0, 32'd0);
    addVec(1'b0, 1'b1, 1'b0, 11'd2, 2'd2, 35'd5, 35'd6,   1'b1, 1'b1, 11'd2, 1'b0, 35'd0, 32'd1);
    addVec(1'b1, 1'b0, 1'b0, 11'd0, 2'd0, 35'd0, 35'd0,   1'b0, 1'b0, 11'd0, 1'b0, 35'd0, 32'd0);
    addVec(1'b0, 1'b0, 1'b0, 11'd0, 2'd0, 35'd0, 35'd0,   1'b0, 1'b0, 11'd0, 1'b0, 35'd0, 32'd0);
    // single push
    addVec(1'b0, 1'b1, 1'b0, 11'd0, 2'd1, 35'h1_2345_6789, 35'd0, 1'b0, 1'b0, 11'd0, 1'b1, 35'h1_2345_6789, 32'd1);
    addVec(1'b0, 1'b0, 1'b0, 11'd0, 2'd0, 35'd0, 35'd0,   1'b0, 1'b0, 11'd0, 1'b0, 35'd0, 32'd1);
    // full bundle, next bundle held until the last push cycle
    addVec(1'b0, 1'b1, 1'b0, 11'd3, 2'd3, 35'h11, 35'h22, 1'b1, 1'b1, 11'd3, 1'b0, 35'd0, 32'd2);
    addVec(1'b0, 1'b1, 1'b0, 11'd0, 2'd1, 35'h33, 35'd0,  1'b1, 1'b0, 11'd0, 1'b1, 35'h22, 32'd2);
    addVec(1'b0, 1'b1, 1'b0, 11'd0, 2'd1, 35'h33, 35'd0,  1'b0, 1'b0, 11'd0, 1'b1, 35'h11, 32'd2);
    addVec(1'b0, 1'b1, 1'b0, 11'd0, 2'd1, 35'h33, 35'd0,  1'b0, 1'b0, 11'd0, 1'b1, 35'h33, 32'd3);
    addVec(1'b0, 1'b0, 1'b0, 11'd0, 2'd0, 35'd0, 35'd0,   1'b0, 1'b0, 11'd0, 1'b0, 35'd0, 32'd3);
    // kill, then the same bundle unkilled
    addVec(1'b0, 1'b1, 1'b1, 11'd5, 2'd1, 35'h44, 35'd0,  1'b0, 1'b0, 11'd0, 1'b0, 35'd0, 32'd3);
    addVec(1'b0, 1'b1, 1'b0, 11'd5, 2'd1, 35'h44, 35'd0,  1'b1, 1'b1, 11'd5, 1'b0, 35'd0, 32'd4);
    addVec(1'b0, 1'b0, 1'b0, 11'd0, 2'd0, 35'd0, 35'd0,   1'b0, 1'b0, 11'd0, 1'b1, 35'h44, 32'd4);
    addVec(1'b0, 1'b0, 1'b0, 11'd0, 2'd0, 35'd0, 35'd0,   1'b0, 1'b0, 11'd0, 1'b0, 35'd0, 32'd4);
    // reset beats a simultaneous accept, then four back-to-back max pops
    addVec(1'b1, 1'b1, 1'b0, 11'h7FF, 2'd0, 35'd0, 35'd0, 1'b0, 1'b0, 11'd0, 1'b0, 35'd0, 32'd0);
    for (int i = 1; i <= 4; i++)
      addVec(1'b0, 1'b1, 1'b0, 11'h7FF, 2'd0, 35'd0, 35'd0, 1'b0, 1'b1, 11'h7FF, 1'b0, 35'd0, i);
    addVec(1'b0, 1'b0, 1'b0, 11'd0, 2'd0, 35'd0, 35'd0,   1'b0, 1'b0, 11'd0, 1'b0, 35'd0, 32'd4);

    @(negedge clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].kill, vecs[i].pop, vecs[i].code,
                    vecs[i].r, vecs[i].a);
      checkField($sformatf("vec%0d busy", i), {34'd0, busy_5a}, {34'd0, vecs[i].busy});
      checkField($sformatf("vec%0d pop strobe", i), {34'd0, st__pop_5a}, {34'd0, vecs[i].spop});
      checkField($sformatf("vec%0d pop count", i), {24'd0, st__to_pop_5a}, {24'd0, vecs[i].pcnt});
      checkField($sformatf("vec%0d push strobe", i), {34'd0, st__push_5a}, {34'd0, vecs[i].spush});
      checkField($sformatf("vec%0d push value", i), st__to_push_5a, vecs[i].pval);
      checkField($sformatf("vec%0d retired", i), {3'd0, retired_5a}, {3'd0, vecs[i].ret});
      checkOutput();
    end

    $display("[TB] directed vectors done, starting random run");
    for (int n = 0; n < 3000; n++) begin
      t = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0: rp = 11'd0;
        1: rp = 11'h7FF;
        default: rp = t[60:50];
      endcase
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 4) == 0, rp, t[62:61], t[34:0],
                    {t[31:0], t[63:61]});
      checkOutput();
    end

    // counter wrap with a zero-command bundle
    applyStimulus(1'b1, 1'b0, 1'b0, 11'd0, 2'd0, 35'd0, 35'd0);
    checkOutput();
    force dut.retired_5a = 32'hFFFF_FFFF;
    #1;
    release dut.retired_5a;
    m_cnt = 32'hFFFF_FFFF;
    checkOutput();
    applyStimulus(1'b0, 1'b1, 1'b0, 11'd0, 2'd0, 35'h5, 35'h6);
    checkField("wrap retired", {3'd0, retired_5a}, 35'd0);
    checkField("wrap pop strobe", {34'd0, st__pop_5a}, 35'd0);
    checkField("wrap push strobe", {34'd0, st__push_5a}, 35'd0);
    checkField("wrap busy", {34'd0, busy_5a}, 35'd0);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
